noc_output_arbiter: RTL and testbench

Per-output-port switch allocator and output stage of the NoC router, directly downstream of the five input queues. Each cycle it picks one input queue whose head flit targets this output port, pops that queue, and registers the flit onto the output link. Allocation is round-robin with wormhole locking on multi-flit packets. Credit-based flow control keeps the downstream input queue from overflowing.

---
 rtl/noc_output_arbiter.sv | 118 +++++++++++
 tb/tb_noc_output_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Per-output-port switch allocator: round-robin grant with wormhole locking,
// credit-based flow control toward the downstream queue, and a registered output flit.
module noc_output_arbiter #(
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned DW      = 16,
    parameter int unsigned CREDITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    req_i,
    input  logic [NUM_IN-1:0]    en_i,
    input  logic [NUM_IN*DW-1:0] data_i,
    output logic [NUM_IN-1:0]    pop_o,
    output logic [DW-1:0]        data_o,
    output logic                 valid_o,
    input  logic                 credit_ret_i
);
    localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned CW = $clog2(CREDITS + 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     lock_idx_q, lock_idx_d;
    logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
    logic [NUM_IN-1:0] eligible;
    logic              send_ok, found, grant, grant_tail;
    logic [PW-1:0]     grant_idx, next_idx;
    logic [DW-1:0]     grant_flit;

    assign eligible   = req_i & en_i;
    assign send_ok    = (credit_cnt_q != '0);
    assign grant      = found && send_ok;
    assign grant_flit = data_i[grant_idx*DW +: DW];
    assign grant_tail = grant_flit[DW-1];
    assign next_idx   = (grant_idx == PW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

    // Candidate selection: rotating search when idle, only the locked queue mid-packet.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        if (state_q == StIdle) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!found && eligible[(32'(rr_ptr_q) + i) % NUM_IN]) begin
                    found     = 1'b1;
                    grant_idx = PW'((32'(rr_ptr_q) + i) % NUM_IN);
                end
            end
        end else begin
            found     = eligible[lock_idx_q];
            grant_idx = lock_idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    if (grant_tail) begin
                        rr_ptr_d = next_idx;
                    end else begin
                        state_d    = StLocked;
                        lock_idx_d = grant_idx;
                    end
                end
            end
            StLocked: begin
                if (grant && grant_tail) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_idx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop_o = '0;
        if (grant && !rst) begin
            pop_o[grant_idx] = 1'b1;
        end
    end

    // A return at full credit is dropped; the zero-credit check already used the old count.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        if (grant && !credit_ret_i) begin
            credit_cnt_d = credit_cnt_q - 1'b1;
        end else if (!grant && credit_ret_i && credit_cnt_q != CW'(CREDITS)) begin
            credit_cnt_d = credit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            credit_cnt_q <= CW'(CREDITS);
            valid_o      <= 1'b0;
            data_o       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            credit_cnt_q <= credit_cnt_d;
            valid_o      <= grant;
            if (grant) begin
                data_o <= grant_flit;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed test-plan steps plus randomized traffic,
// all checked against a packet-level reference model of allocation and credits.
module tb_noc_output_arbiter;
    localparam int NUM_IN  = 5;
    localparam int DW      = 16;
    localparam int CREDITS = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_IN-1:0]    req_i, en_i, pop_o;
    logic [NUM_IN*DW-1:0] data_i;
    logic [DW-1:0]        data_o;
    logic                 valid_o, credit_ret_i;

    always #5 clk = ~clk;

    noc_output_arbiter #(
        .NUM_IN (NUM_IN),
        .DW     (DW),
        .CREDITS(CREDITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .en_i        (en_i),
        .data_i      (data_i),
        .pop_o       (pop_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .credit_ret_i(credit_ret_i)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: packet owner (or none), rotation start, credits in hand, output register.
    bit            m_locked = 1'b0;
    int            m_lock   = 0;
    int            m_rr     = 0;
    int            m_cred   = CREDITS;
    logic          m_valid  = 1'b0;
    logic [DW-1:0] m_data   = '0;
    int            exp_g    = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit elig(input int k);
        return req_i[k] && en_i[k];
    endfunction

    function automatic int pick();
        if (rst || m_cred == 0) return -1;
        if (m_locked) return elig(m_lock) ? m_lock : -1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (elig((m_rr + i) % NUM_IN)) return (m_rr + i) % NUM_IN;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int k);
        return (k < 0) ? 32'd0 : (32'd1 << k);
    endfunction

    task automatic eval();
        #1;
        exp_g = pick();
        check("pop_model", 32'(pop_o), onehot(exp_g));
    endtask

    task automatic tick();
        logic [DW-1:0] f;
        @(posedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_lock   = 0;
            m_rr     = 0;
            m_cred   = CREDITS;
            m_valid  = 1'b0;
            m_data   = '0;
        end else begin
            m_valid = (exp_g >= 0);
            if (exp_g >= 0) begin
                f      = data_i[exp_g*DW +: DW];
                m_data = f;
                if (f[DW-1]) begin
                    m_locked = 1'b0;
                    m_rr     = (exp_g + 1) % NUM_IN;
                end else begin
                    m_locked = 1'b1;
                    m_lock   = exp_g;
                end
            end
            if (exp_g >= 0 && !credit_ret_i) m_cred--;
            else if (exp_g < 0 && credit_ret_i && m_cred < CREDITS) m_cred++;
        end
        #1;
        check("valid_model", 32'(valid_o), 32'(m_valid));
        check("data_model", 32'(data_o), 32'(m_data));
        @(negedge clk);
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    task automatic cyc_pop(input string tag, input int k);
        eval();
        check(tag, 32'(pop_o), onehot(k));
        tick();
    endtask

    task automatic set_flit(input int k, input logic [DW-1:0] v);
        data_i[k*DW +: DW] = v;
    endtask

    task automatic drive(input logic [NUM_IN-1:0] r, input logic [NUM_IN-1:0] e, input logic c);
        req_i        = r;
        en_i         = e;
        credit_ret_i = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int order1[6] = '{1, 3, 1, 3, 1, 3};
    int order2[6] = '{4, 1, 3, 4, 1, 3};
    int order6[5] = '{0, 4, 0, 4, -1};

    initial begin
        rst = 1'b1;
        drive('1, '1, 1'b0);
        data_i = '0;
        for (int k = 0; k < NUM_IN; k++) set_flit(k, 16'h8000 + 16'(k));
        // Reset with everything eligible: pop forced low, outputs cleared.
        cyc_pop("rst_pop", -1);
        cyc_pop("rst_pop", -1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);

        // 1: burst of four, then stall on zero credit.
        rst = 1'b0;
        for (int c = 0; c < 4; c++) cyc_pop("t1_burst", c);
        check("t1_last_data", 32'(data_o), 32'h8003);
        cyc_pop("t1_stall", -1);
        check("t1_stall_valid", 32'(valid_o), 32'd0);
        cyc_pop("t1_stall", -1);

        // 2: continuous send from queue 1 with matching returns.
        do_reset();
        drive(5'b00010, 5'b00010, 1'b1);
        for (int c = 0; c < 20; c++) cyc_pop("t2_balance", 1);
        drive('0, '0, 1'b1);
        cyc_pop("t2_sat", -1);
        drive(5'b00010, 5'b00010, 1'b0);
        for (int c = 0; c < 4; c++) cyc_pop("t2_credits", 1);
        cyc_pop("t2_credits_out", -1);

        // 3: wormhole lock on queue 2 while queue 0 waits.
        do_reset();
        drive(5'b00010, 5'b00010, 1'b1);
        cyc_pop("t3_prime", 1);
        set_flit(0, 16'h8000);
        drive(5'b00101, 5'b00101, 1'b1);
        set_flit(2, 16'h0011); cyc_pop("t3_head", 2);
        set_flit(2, 16'h0022); cyc_pop("t3_body", 2);
        set_flit(2, 16'h8033); cyc_pop("t3_tail", 2);
        en_i[2] = 1'b0;        cyc_pop("t3_after", 0);
        en_i[2] = 1'b1;
        set_flit(2, 16'h0044); cyc_pop("t3_head2", 2);
        en_i[2] = 1'b0;        cyc_pop("t3_gap", -1);
                               cyc_pop("t3_gap", -1);
        en_i[2] = 1'b1;
        set_flit(2, 16'h8055); cyc_pop("t3_tail2", 2);
        en_i[2] = 1'b0;        cyc_pop("t3_after2", 0);

        // 4: round-robin between 1 and 3, then 1,3,4.
        do_reset();
        for (int k = 0; k < NUM_IN; k++) set_flit(k, 16'h8000 + 16'(k));
        drive(5'b01010, 5'b01010, 1'b1);
        foreach (order1[i]) cyc_pop("t4_rr2", order1[i]);
        drive(5'b11010, 5'b11010, 1'b1);
        foreach (order2[i]) cyc_pop("t4_rr3", order2[i]);

        // 5: request without head-valid and head-valid without request.
        drive(5'b01000, 5'b00000, 1'b0);
        cyc_pop("t5_req_only", -1);
        cyc_pop("t5_req_only", -1);
        check("t5_valid", 32'(valid_o), 32'd0);
        drive(5'b00000, 5'b01000, 1'b0);
        cyc_pop("t5_en_only", -1);
        check("t5_valid", 32'(valid_o), 32'd0);

        // 6: reset while locked on queue 4 with one credit left.
        do_reset();
        drive(5'b10000, 5'b10000, 1'b0);
        set_flit(4, 16'h0004); cyc_pop("t6_head", 4);
        set_flit(4, 16'h0005); cyc_pop("t6_body", 4);
        set_flit(4, 16'h0006); cyc_pop("t6_body", 4);
        set_flit(4, 16'h8007);
        set_flit(0, 16'h8000);
        drive(5'b10001, 5'b10001, 1'b0);
        rst = 1'b1;
        cyc_pop("t6_rst_pop", -1);
        check("t6_rst_valid", 32'(valid_o), 32'd0);
        rst = 1'b0;
        foreach (order6[i]) cyc_pop("t6_after", order6[i]);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(63) == 0);
            req_i        = NUM_IN'($urandom);
            en_i         = NUM_IN'($urandom);
            credit_ret_i = ($urandom_range(2) == 0);
            for (int k = 0; k < NUM_IN; k++) set_flit(k, DW'($urandom));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
